// File: rtl/mont_pkg.sv
// Shared definitions for the modular exponentiation sequencer:
// FSM state encoding, operand-mux selection and default widths.
// Optional feature macro used by the sequencer: MONT_EXP_LZ_SKIP_EN.
package mont_pkg;

  localparam int WIDTH_DEF     = 1024;
  localparam int EXP_WIDTH_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TOMONT   = 3'd1,
    SCAN     = 3'd2,
    SQR      = 3'd3,
    MUL      = 3'd4,
    FROMMONT = 3'd5,
    DONE     = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE     = 3'd0,
    OP_TOMONT   = 3'd1,
    OP_SQR      = 3'd2,
    OP_MUL      = 3'd3,
    OP_FROMMONT = 3'd4
  } op_sel_t;

  // Which multiplier operation (if any) a state issues.
  function automatic op_sel_t op_sel_of(input state_t s);
    op_sel_t sel;
    case (s)
      TOMONT:   sel = OP_TOMONT;
      SQR:      sel = OP_SQR;
      MUL:      sel = OP_MUL;
      FROMMONT: sel = OP_FROMMONT;
      default:  sel = OP_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mont_exp_bit_iter.sv
// Exponent register plus MSB-first bit index for the exponentiation sequencer.
// The index counts down and saturates at zero; callers test last_bit before stepping.
module mont_exp_bit_iter
  import mont_pkg::*;
#(
  parameter int EXP_WIDTH = EXP_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic                 step,
  input  logic [EXP_WIDTH-1:0] exp_value,
  output logic                 cur_bit,
  output logic                 last_bit,
  output logic                 lz
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  logic [EXP_WIDTH-1:0] e_r;
  logic [IDX_W-1:0]     idx_r;

  // Exponent capture and saturating bit-index down-counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_r   <= {EXP_WIDTH{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else if (load) begin
      e_r   <= exp_value;
      idx_r <= IDX_W'(EXP_WIDTH - 1);
    end else if (step && (idx_r != {IDX_W{1'b0}})) begin
      idx_r <= idx_r - IDX_W'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  assign cur_bit  = e_r[idx_r];
  assign last_bit = (idx_r == {IDX_W{1'b0}});
  // Current bit is zero and more bits remain below it: it can be skipped over.
  assign lz       = ~cur_bit & ~last_bit;

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right binary modular exponentiation sequencer (result = x^e mod M).
// Drives one shared Montgomery multiplier via mm_start/mm_done and owns the
// operand mux and the Montgomery-domain accumulator.
// Optional feature: define MONT_EXP_LZ_SKIP_EN to skip leading zero exponent
// bits (SCAN state, one cycle per bit, no multiplier operations).
module mont_exp_ctrl
  import mont_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int EXP_WIDTH = EXP_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_r2,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH-1:0]     mm_result,
  input  logic                 mm_done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r, next_state_s;
  logic             wait_r, next_wait_s;
  logic             load_s, step_s, cap_s, issue_next_s;
  logic             cur_bit_s, last_bit_s, lz_s;
  logic [WIDTH-1:0] acc_r, acc_next_s;
  logic [WIDTH-1:0] xm_r, xm_next_s;
  logic [WIDTH-1:0] m_r, m_next_s;
  logic [WIDTH-1:0] result_r, result_next_s;
  logic [WIDTH-1:0] mm_a_r, mm_b_r, op_a_s, op_b_s;
  logic             mm_start_r, done_r, busy_r;

  mont_exp_bit_iter #(
    .EXP_WIDTH (EXP_WIDTH)
  ) u_bit_iter (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load_s),
    .step      (step_s),
    .exp_value (in_e),
    .cur_bit   (cur_bit_s),
    .last_bit  (last_bit_s),
    .lz        (lz_s)
  );

  // FSM state and issue/wait phase register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      wait_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      wait_r  <= next_wait_s;
    end
  end

  // Next-state logic: each op state has an issue cycle (wait_r=0) then waits for mm_done
  always_comb begin
    next_state_s = state_r;
    next_wait_s  = wait_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    cap_s        = 1'b0;
    case (state_r)
      IDLE: begin
        next_wait_s = 1'b0;
        if (start) begin
          next_state_s = TOMONT;
          load_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      TOMONT: begin
        if (!wait_r) begin
          next_wait_s = 1'b1;
        end else if (mm_done) begin
          cap_s       = 1'b1;
          next_wait_s = 1'b0;
`ifdef MONT_EXP_LZ_SKIP_EN
          next_state_s = SCAN;
`else
          next_state_s = SQR;
`endif
        end else begin
          next_wait_s = 1'b1;
        end
      end
      SCAN: begin
        next_wait_s = 1'b0;
`ifdef MONT_EXP_LZ_SKIP_EN
        if (cur_bit_s) begin
          next_state_s = SQR;
        end else if (lz_s) begin
          step_s       = 1'b1;
          next_state_s = SCAN;
        end else begin
          next_state_s = FROMMONT;
        end
`else
        next_state_s = IDLE;
`endif
      end
      SQR: begin
        if (!wait_r) begin
          next_wait_s = 1'b1;
        end else if (mm_done) begin
          cap_s       = 1'b1;
          next_wait_s = 1'b0;
          if (cur_bit_s) begin
            next_state_s = MUL;
          end else if (lz_s) begin
            step_s       = 1'b1;
            next_state_s = SQR;
          end else begin
            next_state_s = FROMMONT;
          end
        end else begin
          next_wait_s = 1'b1;
        end
      end
      MUL: begin
        if (!wait_r) begin
          next_wait_s = 1'b1;
        end else if (mm_done) begin
          cap_s       = 1'b1;
          next_wait_s = 1'b0;
          if (last_bit_s) begin
            next_state_s = FROMMONT;
          end else begin
            step_s       = 1'b1;
            next_state_s = SQR;
          end
        end else begin
          next_wait_s = 1'b1;
        end
      end
      FROMMONT: begin
        if (!wait_r) begin
          next_wait_s = 1'b1;
        end else if (mm_done) begin
          cap_s        = 1'b1;
          next_wait_s  = 1'b0;
          next_state_s = DONE;
        end else begin
          next_wait_s = 1'b1;
        end
      end
      DONE: begin
        next_wait_s  = 1'b0;
        next_state_s = IDLE;
      end
      default: begin
        next_wait_s  = 1'b0;
        next_state_s = IDLE;
      end
    endcase
  end

  assign issue_next_s = (op_sel_of(next_state_s) != OP_NONE) && !next_wait_s;

  // Next values of the accumulator, x in Montgomery form, modulus and result
  always_comb begin
    acc_next_s    = acc_r;
    xm_next_s     = xm_r;
    m_next_s      = m_r;
    result_next_s = result_r;
    if (load_s) begin
      acc_next_s = in_r;
      m_next_s   = in_m;
    end else if (cap_s) begin
      case (state_r)
        TOMONT:   xm_next_s     = mm_result;
        SQR:      acc_next_s    = mm_result;
        MUL:      acc_next_s    = mm_result;
        FROMMONT: result_next_s = mm_result;
        default:  acc_next_s    = acc_r;
      endcase
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Operand mux for the operation issued next cycle; operands hold otherwise.
  // TOMONT is only ever issued straight after start, so x and R^2 come
  // directly from the inputs and are held in the operand registers.
  always_comb begin
    op_a_s = mm_a_r;
    op_b_s = mm_b_r;
    if (issue_next_s) begin
      case (op_sel_of(next_state_s))
        OP_TOMONT: begin
          op_a_s = in_x;
          op_b_s = in_r2;
        end
        OP_SQR: begin
          op_a_s = acc_next_s;
          op_b_s = acc_next_s;
        end
        OP_MUL: begin
          op_a_s = acc_next_s;
          op_b_s = xm_next_s;
        end
        OP_FROMMONT: begin
          op_a_s = acc_next_s;
          op_b_s = ONE;
        end
        default: begin
          op_a_s = mm_a_r;
          op_b_s = mm_b_r;
        end
      endcase
    end else begin
      op_a_s = mm_a_r;
      op_b_s = mm_b_r;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_r      <= {WIDTH{1'b0}};
      xm_r       <= {WIDTH{1'b0}};
      m_r        <= {WIDTH{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      mm_a_r     <= {WIDTH{1'b0}};
      mm_b_r     <= {WIDTH{1'b0}};
      mm_start_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      acc_r      <= acc_next_s;
      xm_r       <= xm_next_s;
      m_r        <= m_next_s;
      result_r   <= result_next_s;
      mm_a_r     <= op_a_s;
      mm_b_r     <= op_b_s;
      mm_start_r <= issue_next_s;
      done_r     <= (next_state_s == DONE);
      busy_r     <= (next_state_s != IDLE) && (next_state_s != DONE);
    end
  end

  assign result   = result_r;
  assign done     = done_r;
  assign busy     = busy_r;
  assign mm_start = mm_start_r;
  assign mm_a     = mm_a_r;
  assign mm_b     = mm_b_r;
  assign mm_m     = m_r;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench for mont_exp_ctrl with WIDTH=EXP_WIDTH=16, M=1009.
// A behavioural Montgomery multiplier answers mm_start after a random latency;
// results are compared with plain modular exponentiation.
module tb_mont_exp_ctrl;

  localparam int MOD = 1009;

  logic        clk, resetn, start;
  logic [15:0] in_x, in_e, in_m, in_r, in_r2;
  logic [15:0] result, mm_a, mm_b, mm_m, mm_result;
  logic        done, busy, mm_start, mm_done;
  logic        model_done, stray_done;

  int     checks, errors, mm_cnt;
  bit     fast_mode;
  longint rinv;

  assign mm_done = model_done | stray_done;

  mont_exp_ctrl #(.WIDTH(16), .EXP_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
    .result(result), .done(done), .busy(busy),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mm_model(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = (longint'(a) * longint'(b)) % MOD;
    p = (p * rinv) % MOD;
    return 16'(p);
  endfunction

  function automatic longint pow_mod(input longint x, input longint e);
    longint r, b, k;
    r = 1;
    b = x % MOD;
    k = e;
    while (k > 0) begin
      if ((k % 2) == 1) r = (r * b) % MOD;
      b = (b * b) % MOD;
      k = k / 2;
    end
    return r % MOD;
  endfunction

  function automatic int exp_mm(input logic [15:0] e);
    int nsq;
    nsq = 16;
`ifdef MONT_EXP_LZ_SKIP_EN
    nsq = 0;
    for (int k = 0; k < 16; k++) if (e[k]) nsq = k + 1;
`endif
    return 2 + nsq + $countones(e);
  endfunction

  // Behavioural multiplier: captures operands at mm_start, checks they hold, answers later
  logic [15:0] cap_a, cap_b;
  int          lat;
  bit          aborted;
  initial begin
    model_done = 1'b0;
    mm_result  = 16'd0;
    forever begin
      @(posedge clk); #1;
      model_done = 1'b0;
      if (resetn === 1'b1 && mm_start === 1'b1) begin
        cap_a = mm_a;
        cap_b = mm_b;
        mm_cnt++;
        aborted = 1'b0;
        lat = fast_mode ? (($urandom_range(3, 0) == 0) ? 1 : 0) : int'($urandom_range(3, 0));
        for (int k = 0; k <= lat; k++) begin
          @(posedge clk); #1;
          if (resetn !== 1'b1) aborted = 1'b1;
          if (!aborted) begin
            chk("mm_a_stable", mm_a, cap_a);
            chk("mm_b_stable", mm_b, cap_b);
            chk("mm_start_pulse", mm_start, 1'b0);
          end
        end
        if (!aborted) begin
          mm_result  = mm_model(cap_a, cap_b);
          model_done = 1'b1;
        end
      end
    end
  end

  task automatic run_exp(input logic [15:0] x, input logic [15:0] e, input bit mid_start,
                         output logic [15:0] res, output int ndone, output int nmm);
    int base;
    @(negedge clk);
    in_x  = x;
    in_e  = e;
    start = 1'b1;
    base  = mm_cnt;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      if (done === 1'b1) break;
      if (mid_start && c == 5) begin
        in_x  = 16'd7;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", done, 1'b1);
    chk("busy_low_at_done", busy, 1'b0);
    chk("mm_m", mm_m, 16'd1009);
    res   = result;
    ndone = (done === 1'b1) ? 1 : 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    nmm = mm_cnt - base;
  endtask

  logic [15:0] res, rx, re, held;
  int          nd, nm, base;

  initial begin
    checks = 0; errors = 0; mm_cnt = 0; fast_mode = 1'b0;
    rinv = 0;
    for (int k = 1; k < MOD; k++) if (((960 * k) % MOD) == 1) rinv = k;
    resetn = 1'b0; start = 1'b0; stray_done = 1'b0;
    in_x = 16'd0; in_e = 16'd0; in_m = 16'd1009; in_r = 16'd960; in_r2 = 16'd383;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_result", result, 16'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mm_start", mm_start, 1'b0);
    chk("rst_mm_a", mm_a, 16'd0);
    chk("rst_mm_m", mm_m, 16'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // 2^10 mod 1009 = 15
    run_exp(16'd2, 16'd10, 1'b0, res, nd, nm);
    chk("x2_e10_result", res, 16'd15);
    chk("x2_e10_done_cnt", nd, 1);
    chk("x2_e10_mm_cnt", nm, exp_mm(16'd10));

    // Fermat and e=1
    run_exp(16'd3, 16'd1008, 1'b0, res, nd, nm);
    chk("fermat_result", res, 16'd1);
    chk("fermat_mm_cnt", nm, exp_mm(16'd1008));
    run_exp(16'd5, 16'd1, 1'b0, res, nd, nm);
    chk("x5_e1_result", res, 16'd5);

    // e = 0
    run_exp(16'd123, 16'd0, 1'b0, res, nd, nm);
    chk("e0_result", res, 16'd1);
    chk("e0_mm_cnt", nm, exp_mm(16'd0));

    // start while busy is ignored
    run_exp(16'd2, 16'd10, 1'b1, res, nd, nm);
    chk("midstart_result", res, 16'd15);
    chk("midstart_done_cnt", nd, 1);
    chk("midstart_mm_cnt", nm, exp_mm(16'd10));

    // mm_done while idle is ignored
    held = result;
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    chk("stray_busy", busy, 1'b0);
    chk("stray_done", done, 1'b0);
    chk("stray_result", result, held);
    run_exp(16'd5, 16'd1, 1'b0, res, nd, nm);
    chk("after_stray_result", res, 16'd5);

    // Reset during SQR
    @(negedge clk);
    in_x = 16'd2; in_e = 16'd10; start = 1'b1; base = mm_cnt;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (mm_cnt - base >= 2) break;
      @(negedge clk);
    end
    chk("sqr_reached", (mm_cnt - base >= 2), 1'b1);
    resetn = 1'b0;
    #1;
    chk("midrst_result", result, 16'd0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_mm_start", mm_start, 1'b0);
    chk("midrst_state", dut.state_r, mont_pkg::IDLE);
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    run_exp(16'd2, 16'd10, 1'b0, res, nd, nm);
    chk("post_rst_result", res, 16'd15);
    chk("post_rst_done_cnt", nd, 1);

    // Randomized runs against pow(x, e, M)
    fast_mode = 1'b1;
    for (int it = 0; it < 1000; it++) begin
      rx = 16'($urandom_range(MOD - 1, 0));
      re = 16'($urandom_range(65535, 0));
      run_exp(rx, re, 1'b0, res, nd, nm);
      chk("rand_result", res, 16'(pow_mod(longint'(rx), longint'(re))));
      chk("rand_done_cnt", nd, 1);
      chk("rand_mm_cnt", nm, exp_mm(re));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
